// File: rtl/ita_output_stage.sv
// Output stage: row FIFO with early stall, overflow flag and row-to-beat narrowing
// onto a valid/ready consumer port.
module ita_output_stage #(
   parameter int unsigned N          = 16,
   parameter int unsigned WI         = 8,
   parameter int unsigned OUT_LANES  = 16,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned PIPE_SLACK = 4
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             flush_i,
   input  logic                             data_valid_i,
   input  logic [N*WI-1:0]                  data_i,
   output logic                             stall_o,
   output logic                             overflow_o,
   output logic                             valid_o,
   input  logic                             ready_i,
   output logic [OUT_LANES*WI-1:0]          oup_o,
   output logic                             last_beat_o,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  usage_o,
   output logic                             busy_o
);

   localparam int unsigned B      = N / OUT_LANES;
   localparam int unsigned SliceW = OUT_LANES * WI;
   localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW   = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned SW     = (B > 1) ? $clog2(B) : 1;

   logic [N*WI-1:0]         mem_q [FIFO_DEPTH];
   logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]         usage_q, usage_d;
   logic [SW-1:0]           slice_q, slice_d;
   logic                    overflow_q, overflow_d;
   logic                    full, last_slice, beat, pop, push;
   logic [B-1:0][SliceW-1:0] head;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Outputs depend only on registered state, never combinationally on ready_i.
   always_comb begin
      full        = (usage_q == CntW'(FIFO_DEPTH));
      valid_o     = (usage_q != '0);
      last_slice  = (slice_q == SW'(B - 1));
      beat        = valid_o && ready_i;
      pop         = beat && last_slice;
      push        = data_valid_i && (!full || pop);
      head        = mem_q[rd_ptr_q];
      oup_o       = valid_o ? head[slice_q] : '0;
      last_beat_o = valid_o && last_slice;
      stall_o     = (usage_q >= CntW'(FIFO_DEPTH - PIPE_SLACK));
      busy_o      = valid_o;
      usage_o     = usage_q;
      overflow_o  = overflow_q;
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      usage_d    = usage_q;
      slice_d    = slice_q;
      overflow_d = overflow_q;
      if (beat) begin
         slice_d = last_slice ? '0 : slice_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (push) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (data_valid_i && full && !pop) begin
         overflow_d = 1'b1;
      end
      unique case ({push, pop})
         2'b10:   usage_d = usage_q + 1'b1;
         2'b01:   usage_d = usage_q - 1'b1;
         default: usage_d = usage_q;
      endcase
      // Flush wins over any same-cycle push or pop.
      if (flush_i) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         usage_d    = '0;
         slice_d    = '0;
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         usage_q    <= '0;
         slice_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         usage_q    <= usage_d;
         slice_q    <= slice_d;
         overflow_q <= overflow_d;
      end
   end

   // Row storage needs no reset; usage gates every read.
   always_ff @(posedge clk_i) begin
      if (rst_ni && !flush_i && push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: tb/tb_ita_output_stage.sv
// Randomized and directed bench for ita_output_stage against a queue-based row model.
module tb_ita_output_stage;

   localparam int unsigned N = 16, WI = 8, OL = 4, DEPTH = 4, SLACK = 2;
   localparam int unsigned B = N / OL;
   localparam int unsigned RW = N * WI, SWD = OL * WI;

   logic           clk = 1'b0;
   logic           rst_n, flush, data_valid, ready;
   logic [RW-1:0]  data;
   logic           stall, overflow, valid, last_beat, busy;
   logic [SWD-1:0] oup;
   logic [2:0]     usage;

   int total = 0;
   int bad   = 0;

   logic [RW-1:0] mq[$];
   int            ms = 0;
   bit            mov = 0;

   ita_output_stage #(
      .N(N), .WI(WI), .OUT_LANES(OL), .FIFO_DEPTH(DEPTH), .PIPE_SLACK(SLACK)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .data_valid_i(data_valid),
      .data_i(data), .stall_o(stall), .overflow_o(overflow), .valid_o(valid),
      .ready_i(ready), .oup_o(oup), .last_beat_o(last_beat), .usage_o(usage),
      .busy_o(busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Drive one cycle: compare outputs with the model before the edge, then advance the model.
   task automatic step(input logic r, input logic f, input logic dv, input logic [RW-1:0] d,
                       input logic rdy);
      logic [RW-1:0] row;
      logic [SWD-1:0] exp_oup;
      bit  exp_valid, was_full, popped;
      rst_n = r; flush = f; data_valid = dv; data = d; ready = rdy;
      @(negedge clk);
      exp_valid = (mq.size() != 0);
      exp_oup   = '0;
      if (exp_valid) begin
         row     = mq[0];
         exp_oup = row[ms*SWD +: SWD];
      end
      check_eq("valid", RW'(valid), RW'(exp_valid));
      check_eq("oup", RW'(oup), RW'(exp_oup));
      check_eq("last", RW'(last_beat), RW'(exp_valid && ms == B - 1));
      check_eq("usage", RW'(usage), RW'(mq.size()));
      check_eq("busy", RW'(busy), RW'(exp_valid));
      check_eq("stall", RW'(stall), RW'(mq.size() >= DEPTH - SLACK));
      check_eq("overflow", RW'(overflow), RW'(mov));
      if (!r || f) begin
         mq.delete(); ms = 0; mov = 0;
      end else begin
         was_full = (mq.size() == DEPTH);
         popped   = 0;
         if (exp_valid && rdy) begin
            if (ms == B - 1) begin
               ms = 0; void'(mq.pop_front()); popped = 1;
            end else ms++;
         end
         if (dv) begin
            if (!was_full || popped) mq.push_back(d);
            else mov = 1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [RW-1:0] rand_row();
      logic [RW-1:0] r;
      for (int i = 0; i < RW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   logic [RW-1:0] lane_row;

   initial begin
      rst_n = 1'b0; flush = 1'b0; data_valid = 1'b0; data = '0; ready = 1'b0;
      for (int i = 0; i < RW / WI; i++) lane_row[i*WI +: WI] = WI'(i);
      repeat (2) @(posedge clk);
      #1;
      step(1'b0, 1'b0, 1'b0, '0, 1'b0);

      // Narrowing: lane k holds k
      step(1'b1, 1'b0, 1'b1, lane_row, 1'b0);
      check_eq("narrow_b0", RW'(oup), RW'(32'h03020100));
      step(1'b1, 1'b0, 1'b0, '0, 1'b1);
      check_eq("narrow_b1", RW'(oup), RW'(32'h07060504));
      step(1'b1, 1'b0, 1'b0, '0, 1'b1);
      check_eq("narrow_b2", RW'(oup), RW'(32'h0B0A0908));
      step(1'b1, 1'b0, 1'b0, '0, 1'b1);
      check_eq("narrow_b3", RW'(oup), RW'(32'h0F0E0D0C));
      check_eq("narrow_last", RW'(last_beat), RW'(1));
      step(1'b1, 1'b0, 1'b0, '0, 1'b1);
      check_eq("narrow_empty", RW'(usage), RW'(0));

      // Back-pressure mid-row
      step(1'b1, 1'b0, 1'b1, rand_row(), 1'b1);
      step(1'b1, 1'b0, 1'b0, '0, 1'b1);
      repeat (5) step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      repeat (4) step(1'b1, 1'b0, 1'b0, '0, 1'b1);

      // Almost-full and overflow
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, 1'b1, rand_row(), 1'b0);
         if (i == 1) check_eq("stall_rise", RW'(stall), RW'(1));
      end
      check_eq("full_usage", RW'(usage), RW'(4));
      check_eq("ovf_set", RW'(overflow), RW'(1));
      repeat (18) step(1'b1, 1'b0, 1'b0, '0, 1'b1);

      // Simultaneous push and pop at full
      step(1'b1, 1'b1, 1'b0, '0, 1'b0);
      repeat (4) step(1'b1, 1'b0, 1'b1, rand_row(), 1'b0);
      repeat (3) step(1'b1, 1'b0, 1'b0, '0, 1'b1);
      step(1'b1, 1'b0, 1'b1, rand_row(), 1'b1);
      check_eq("pp_usage", RW'(usage), RW'(4));
      check_eq("pp_ovf", RW'(overflow), RW'(0));
      repeat (17) step(1'b1, 1'b0, 1'b0, '0, 1'b1);

      // Flush mid-row with a same-cycle push
      step(1'b1, 1'b0, 1'b1, rand_row(), 1'b1);
      repeat (2) step(1'b1, 1'b0, 1'b0, '0, 1'b1);
      step(1'b1, 1'b1, 1'b1, rand_row(), 1'b1);
      check_eq("flush_valid", RW'(valid), RW'(0));
      check_eq("flush_usage", RW'(usage), RW'(0));
      step(1'b1, 1'b0, 1'b1, lane_row, 1'b0);
      check_eq("flush_slice0", RW'(oup), RW'(32'h03020100));

      // Reset during streaming
      step(1'b1, 1'b0, 1'b1, rand_row(), 1'b1);
      step(1'b1, 1'b0, 1'b1, rand_row(), 1'b1);
      step(1'b0, 1'b0, 1'b1, rand_row(), 1'b1);
      check_eq("rst_oup", RW'(oup), RW'(0));
      check_eq("rst_usage", RW'(usage), RW'(0));

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 79) != 0), ($urandom_range(0, 49) == 0),
              ($urandom_range(0, 1) == 1), rand_row(), ($urandom_range(0, 9) < 6));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
